l2_mem_requester: RTL and testbench

Request front-end between the L2 cache and the memory bus arbiter. It buffers L2 read/write commands in a small FIFO and drives the arbiter's L2 request/rw pair under the arbiter's hold rule (request stable for ≥2 cycles). It performs one memory-bus beat per command while the L2 grant and bus enable are both high, and returns completions to L2. It survives preemption by the DSC port without losing or duplicating a command.

---
 rtl/mcu_mem_pkg.sv | 40 ++++
 rtl/l2_req_fifo.sv | 87 ++++++++
 rtl/l2_mem_requester.sv | 192 +++++++++++++++++++
 tb/tb_l2_mem_requester.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_mem_pkg
// Description : Shared memory-subsystem definitions.
//               - Arbiter direction encoding (MEM_RD / MEM_WR).
//               - Default minimum request-hold time, shared with the arbiter.
//               - L2 requester FSM state encoding.
//               - Debug-name helper that returns the state name as packed ASCII.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_mem_pkg;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // The arbiter only honours a request that stays up for this many cycles.
    localparam int DEF_MIN_REQ_HOLD = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4
    } l2_req_state_t;

    // Seven-character, space-padded state name for debug buses and traces.
    function automatic logic [55:0] l2_req_state_name(input l2_req_state_t st);
        case (st)
            ST_IDLE:    return "IDLE   ";
            ST_HOLD:    return "HOLD   ";
            ST_WAIT:    return "WAIT   ";
            ST_XFER:    return "XFER   ";
            ST_RELEASE: return "RELEASE";
            default:    return "UNKNOWN";
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l2_req_fifo
// Description : Synchronous command FIFO of {rw, addr, wdata} with a
//               fall-through head. Also exposes the direction of the entry
//               behind the head so the requester can decide whether a
//               back-to-back beat is possible without dropping the request.
// Ports       : clk_166M66, mcu_sys_rst      clock / sync active-high reset
//               i_push, i_push_*             write side (ignored when full)
//               i_pop                        remove head (ignored when empty)
//               o_full, o_empty              status from registered count
//               o_head_*                     current head entry
//               o_next_valid, o_next_rw      entry behind the head
// Revision    : 1.0 - initial release
// ============================================================================
module l2_req_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_166M66,
    input  logic              mcu_sys_rst,
    input  logic              i_push,
    input  logic              i_push_rw,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_head_rw,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_wdata,
    output logic              o_next_valid,
    output logic              o_next_rw
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_ENTRY_W = 1 + ADDR_W + DATA_W;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_push;
    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_next_ptr;

    assign o_full     = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign w_next_ptr = r_rd_ptr + c_PTR_W'(1);

    assign {o_head_rw, o_head_addr, o_head_wdata} = r_mem[r_rd_ptr];
    assign o_next_valid = (r_count >= (c_PTR_W+1)'(2));
    assign o_next_rw    = r_mem[w_next_ptr][c_ENTRY_W-1];

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk_166M66) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_push_rw, i_push_addr, i_push_wdata};
        end
    end

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_requester
// Description : L2-side front end of the memory bus arbiter. Queues L2
//               commands, raises the L2 request/rw pair while respecting the
//               arbiter's minimum hold time, performs one bus beat per
//               command while grant and bus enable are both high, and returns
//               a one-cycle completion to L2. A grant/enable drop before the
//               ack abandons the beat and retries it from the same head.
// Ports       : clk_166M66 / mcu_sys_rst           clock, sync active-high reset
//               i_cmd_* / o_cmd_ready              L2 command push
//               o_rsp_*                            completion pulse to L2
//               o_l2_requesting, o_l2_rw           request to arbiter
//               i_l2_allow, i_data_bus_enable      arbiter grant / enable
//               o_mem_*, i_mem_rdata, i_mem_ack    memory bus beat
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_requester
    import mcu_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int MIN_REQ_HOLD = DEF_MIN_REQ_HOLD
) (
    input  logic              clk_166M66,
    input  logic              mcu_sys_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_rw,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_rw,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_l2_requesting,
    output logic              o_l2_rw,
    input  logic              i_l2_allow,
    input  logic              i_data_bus_enable,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam int c_HOLD_W = $clog2(MIN_REQ_HOLD + 1);

    l2_req_state_t        r_state;
    l2_req_state_t        w_state_nxt;
    logic                 r_l2_rw;
    logic                 w_l2_rw_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_head_rw;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_wdata;
    logic                 w_next_valid;
    logic                 w_next_rw;

    logic                 w_push;
    logic                 w_requesting;
    logic                 w_grant;
    logic                 w_beat_done;
    logic                 w_hold_done;

    logic                 r_rsp_valid;
    logic                 r_rsp_rw;
    logic [DATA_W-1:0]    r_rsp_rdata;

    assign o_cmd_ready  = !w_full && !mcu_sys_rst;
    assign w_push       = i_cmd_valid && o_cmd_ready;
    assign w_requesting = (r_state == ST_HOLD) || (r_state == ST_WAIT) ||
                          (r_state == ST_XFER);
    assign w_grant      = i_l2_allow && i_data_bus_enable;
    assign w_beat_done  = (r_state == ST_XFER) && w_grant && i_mem_ack;
    // Counts the current cycle, so leaving at the end of it satisfies the hold.
    assign w_hold_done  = (int'(r_hold_cnt) + 1) >= MIN_REQ_HOLD;

    l2_req_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_166M66   (clk_166M66),
        .mcu_sys_rst  (mcu_sys_rst),
        .i_push       (w_push),
        .i_push_rw    (i_cmd_rw),
        .i_push_addr  (i_cmd_addr),
        .i_push_wdata (i_cmd_wdata),
        .i_pop        (w_beat_done),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_rw    (w_head_rw),
        .o_head_addr  (w_head_addr),
        .o_head_wdata (w_head_wdata),
        .o_next_valid (w_next_valid),
        .o_next_rw    (w_next_rw)
    );

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            r_state    <= ST_IDLE;
            r_l2_rw    <= MEM_RD;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_l2_rw <= w_l2_rw_nxt;
            if (w_requesting) begin
                if (int'(r_hold_cnt) < MIN_REQ_HOLD) begin
                    r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                end
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    // Direction is only ever reloaded from IDLE/RELEASE, where the request is
    // low, so the arbiter never sees rw move under a live request.
    always_comb begin
        w_state_nxt = r_state;
        w_l2_rw_nxt = r_l2_rw;
        case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_HOLD;
                    w_l2_rw_nxt = w_head_rw;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // HOLD is also the tail of a completion that came too early;
                // then the head is absent or points the other way.
                if (w_hold_done) begin
                    if (w_empty || (w_head_rw != r_l2_rw)) begin
                        w_state_nxt = ST_RELEASE;
                    end else if (w_grant) begin
                        w_state_nxt = ST_XFER;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_grant) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!w_grant) begin
                    w_state_nxt = ST_WAIT;
                end else if (i_mem_ack) begin
                    if (w_next_valid && (w_next_rw == r_l2_rw)) begin
                        w_state_nxt = ST_XFER;
                    end else if (w_hold_done) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rw    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_beat_done;
            r_rsp_rw    <= w_beat_done && w_head_rw;
            r_rsp_rdata <= (w_beat_done && (w_head_rw == MEM_RD)) ? i_mem_rdata : '0;
        end
    end

    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rw        = r_rsp_rw;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_l2_requesting = w_requesting;
    assign o_l2_rw         = r_l2_rw;
    assign o_mem_addr      = (r_state == ST_XFER) ? w_head_addr  : '0;
    assign o_mem_wdata     = (r_state == ST_XFER) ? w_head_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_requester
// Description : Scoreboard testbench for l2_mem_requester. Accepted commands
//               are queued as expected completions; a monitor pops them as
//               responses appear and also checks the request-hold and
//               rw-stability rules of the arbiter handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_l2_mem_requester;
    import mcu_mem_pkg::*;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 4;
    localparam int MIN_REQ_HOLD = 2;

    logic              clk_166M66 = 1'b0;
    logic              mcu_sys_rst;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_rw;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [DATA_W-1:0] i_cmd_wdata;
    logic              o_rsp_valid;
    logic              o_rsp_rw;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_l2_requesting;
    logic              o_l2_rw;
    logic              i_l2_allow;
    logic              i_data_bus_enable;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ack;

    always #3 clk_166M66 = ~clk_166M66;

    l2_mem_requester #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .MIN_REQ_HOLD (MIN_REQ_HOLD)
    ) dut (
        .clk_166M66        (clk_166M66),
        .mcu_sys_rst       (mcu_sys_rst),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_rw          (i_cmd_rw),
        .i_cmd_addr        (i_cmd_addr),
        .i_cmd_wdata       (i_cmd_wdata),
        .o_rsp_valid       (o_rsp_valid),
        .o_rsp_rw          (o_rsp_rw),
        .o_rsp_rdata       (o_rsp_rdata),
        .o_l2_requesting   (o_l2_requesting),
        .o_l2_rw           (o_l2_rw),
        .i_l2_allow        (i_l2_allow),
        .i_data_bus_enable (i_data_bus_enable),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_rdata       (i_mem_rdata),
        .i_mem_ack         (i_mem_ack)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign i_mem_rdata = mem_fn(o_mem_addr);

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   rsp_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- arbiter / memory model ----------------
    bit grant_block = 1'b0;
    bit force_drop  = 1'b0;
    bit rand_arb    = 1'b0;
    bit ack_block   = 1'b0;
    bit rand_ack    = 1'b0;
    int grant_dly   = 2;

    initial begin
        int  age;
        bit  g;
        age = 0;
        i_l2_allow        = 1'b0;
        i_data_bus_enable = 1'b0;
        i_mem_ack         = 1'b0;
        forever begin
            @(posedge clk_166M66);
            #2;
            if (!o_l2_requesting) begin
                age = 0;
                i_l2_allow        = 1'b0;
                i_data_bus_enable = 1'b0;
            end else begin
                age++;
                g = !grant_block && !force_drop && (age > grant_dly);
                i_l2_allow        = g && (!rand_arb || ($urandom_range(0, 3) != 0));
                i_data_bus_enable = g && (!rand_arb || ($urandom_range(0, 3) != 0));
            end
            i_mem_ack = !ack_block && (!rand_ack || ($urandom_range(0, 1) == 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_req;
    logic        prev_rw;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    int          hi_run;
    int          lo_run;
    int          last_lo_run;

    always @(negedge clk_166M66) begin
        cmd_t c;
        if (mcu_sys_rst) begin
            prev_req = 1'b0;
            hi_run   = 0;
            lo_run   = 0;
        end else begin
            if (o_rsp_valid) begin
                check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    c = exp_q.pop_front();
                    rsp_count++;
                    check("rsp_rw", 64'(o_rsp_rw), 64'(c.rw));
                    check("rsp_rdata", 64'(o_rsp_rdata), (c.rw == MEM_WR) ? 64'd0 : 64'(mem_fn(c.addr)));
                    check("beat_addr", 64'(prev_addr), 64'(c.addr));
                    if (c.rw == MEM_WR) check("beat_wdata", 64'(prev_wdata), 64'(c.wdata));
                    // Beat cycle must follow at least MIN_REQ_HOLD held cycles.
                    check("beat_after_hold", 64'(hi_run > MIN_REQ_HOLD), 64'd1);
                end
            end
            if (prev_req && !o_l2_requesting)
                check("req_hold_len", 64'(hi_run >= MIN_REQ_HOLD), 64'd1);
            if (prev_req && o_l2_requesting)
                check("rw_stable", 64'(o_l2_rw), 64'(prev_rw));
            if (o_l2_requesting) begin
                if (!prev_req) last_lo_run = lo_run;
                hi_run = prev_req ? hi_run + 1 : 1;
                lo_run = 0;
            end else begin
                hi_run = 0;
                lo_run++;
            end
            prev_req = o_l2_requesting;
        end
        prev_rw    = o_l2_rw;
        prev_addr  = o_mem_addr;
        prev_wdata = o_mem_wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_166M66);
            #1;
        end
    endtask

    task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        while (!o_cmd_ready && t < 200) begin
            tick(1);
            t++;
        end
        if (!o_cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: o_cmd_ready stayed 0, expected 1 at %0t", $time);
            return;
        end
        i_cmd_valid = 1'b1;
        i_cmd_rw    = rw;
        i_cmd_addr  = a;
        i_cmd_wdata = d;
        exp_q.push_back('{rw: rw, addr: a, wdata: d});
        tick(1);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            tick(1);
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_xfer();
        int t;
        t = 0;
        while (!(o_l2_requesting && i_l2_allow && i_data_bus_enable) && t < 100) begin
            tick(1);
            t++;
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int t;
        mcu_sys_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_rw    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        tick(3);
        check("rst_ready",   64'(o_cmd_ready),     64'd0);
        check("rst_req",     64'(o_l2_requesting), 64'd0);
        check("rst_rw",      64'(o_l2_rw),         64'd0);
        check("rst_rsp",     64'(o_rsp_valid),     64'd0);
        check("rst_addr",    64'(o_mem_addr),      64'd0);
        mcu_sys_rst = 1'b0;
        tick(1);
        check("ready_after_rst", 64'(o_cmd_ready), 64'd1);

        // Single read of the 0x40 location.
        send(MEM_RD, 32'h0000_0040, 32'h0);
        wait_drain(50);
        tick(3);
        check("idle_after_read", 64'(o_l2_requesting), 64'd0);

        // Four writes fill the FIFO, then stream one beat per cycle.
        grant_block = 1'b1;
        for (int i = 0; i < 4; i++) send(MEM_WR, 32'h100 + 32'(i * 4), $urandom);
        check("full_ready", 64'(o_cmd_ready), 64'd0);
        start = rsp_count;
        grant_block = 1'b0;
        t = 0;
        while (rsp_count == start && t < 100) begin
            tick(1);
            t++;
        end
        tick(3);
        check("b2b_rsps", 64'(rsp_count), 64'(start + 4));
        check("ready_back", 64'(o_cmd_ready), 64'd1);
        wait_drain(50);

        // Read then write: one low cycle between the two requests.
        send(MEM_RD, 32'h200, 32'h0);
        send(MEM_WR, 32'h204, 32'hCAFE_F00D);
        wait_drain(100);
        check("release_one_cycle", 64'(last_lo_run), 64'd1);

        // Preemption mid-beat.
        ack_block = 1'b1;
        send(MEM_RD, 32'h300, 32'h0);
        wait_xfer();
        start = rsp_count;
        force_drop = 1'b1;
        tick(4);
        check("preempt_req_high", 64'(o_l2_requesting), 64'd1);
        check("preempt_no_rsp", 64'(rsp_count), 64'(start));
        force_drop = 1'b0;
        ack_block  = 1'b0;
        wait_drain(100);
        tick(3);
        check("preempt_one_rsp", 64'(rsp_count), 64'(start + 1));

        // Reset in the middle of a transfer with three entries queued.
        ack_block = 1'b1;
        send(MEM_RD, 32'h400, 32'h0);
        send(MEM_RD, 32'h404, 32'h0);
        send(MEM_RD, 32'h408, 32'h0);
        wait_xfer();
        start = rsp_count;
        mcu_sys_rst = 1'b1;
        #1;
        check("rst_ready_comb", 64'(o_cmd_ready), 64'd0);
        exp_q.delete();
        @(posedge clk_166M66);
        #1;
        check("midrst_req",   64'(o_l2_requesting), 64'd0);
        check("midrst_rw",    64'(o_l2_rw),         64'd0);
        check("midrst_rsp",   64'(o_rsp_valid),     64'd0);
        check("midrst_addr",  64'(o_mem_addr),      64'd0);
        check("midrst_wdata", 64'(o_mem_wdata),     64'd0);
        mcu_sys_rst = 1'b0;
        ack_block   = 1'b0;
        tick(10);
        check("no_rsp_after_rst", 64'(rsp_count), 64'(start));
        send(MEM_WR, 32'h500, 32'h1234_5678);
        wait_drain(100);

        // Push while popping at full; completion order must be preserved.
        grant_block = 1'b1;
        for (int i = 0; i < 4; i++) send(MEM_RD, 32'h10 + 32'(i * 4), 32'h0);
        grant_block = 1'b0;
        send(MEM_RD, 32'h20, 32'h0);
        wait_drain(100);

        // Randomised traffic with a random arbiter and random acks.
        rand_arb = 1'b1;
        rand_ack = 1'b1;
        begin
            logic rw;
            rw = MEM_RD;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0) rw = ~rw;
                send(rw, {$urandom_range(0, 16'hFFFF), 2'b00}, $urandom);
                if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
            end
        end
        wait_drain(3000);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
